// File: rtl/output_collector_pkg.sv
// Shared configuration for the systolic-array output collector: array geometry,
// buffer sizing, tile height and the aligned result-row type.
package output_collector_pkg;

    localparam int sys_cols            = 4;
    localparam int P_BITWIDTH          = 32;
    localparam int output_buffer_depth = 8;
    localparam int W_rows              = 3;

    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] result_row_t;

    // Bit width able to hold 0..v-1, never narrower than one bit.
    function automatic int index_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/output_collector_col_fifo.sv
// Single-clock FIFO for one array column. The head word is presented
// combinationally; full/empty come from an extra-bit pointer compare.
module col_fifo #(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] din,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic              do_wr_s;
    logic              do_rd_s;

    // Status flags, head word and qualified read/write strobes.
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        dout    = mem_r[rd_ptr_r[AW-1:0]];
        do_wr_s = wr_en && !full;
        do_rd_s = rd_en && !empty;
    end

    // Pointer update; both wrap naturally through the extra lap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/output_collector.sv
// Receive side of the systolic array: per-column FIFOs absorb the output skew,
// re-assembled rows leave through a one-deep valid/ready register with tile marking.
module output_collector
    import output_collector_pkg::*;
#(
    parameter int SYS_COLS   = sys_cols,
    parameter int P_BITWIDTH = output_collector_pkg::P_BITWIDTH,
    parameter int DEPTH      = output_buffer_depth,
    parameter int TILE_ROWS  = W_rows
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SYS_COLS-1:0]                  i_valid,
    input  logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  i_data,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  o_data,
    output logic                                 o_last,
    output logic                                 tile_done,
    output logic [SYS_COLS-1:0]                  full,
    output logic                                 overflow
);

    localparam int CW = index_width(TILE_ROWS);
    localparam logic [CW-1:0] LAST_ROW = CW'(TILE_ROWS - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [SYS_COLS-1:0]                 empty_s;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] head_s;
    logic                                row_ready_s;
    logic                                load_s;
    logic                                accept_s;
    logic                                last_row_s;

    logic                                valid_r;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] data_r;
    logic [CW-1:0]                       count_r;
    logic                                tile_done_r;
    logic                                overflow_r;

    for (genvar g = 0; g < SYS_COLS; g++) begin : g_lane
        col_fifo #(
            .DEPTH  (DEPTH),
            .DWIDTH (P_BITWIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (i_valid[g]),
            .din   (i_data[g]),
            .rd_en (load_s),
            .dout  (head_s[g]),
            .empty (empty_s[g]),
            .full  (full[g])
        );
    end

    // A row exists only once every lane holds a word; pop all lanes together.
    always_comb begin
        row_ready_s = &(~empty_s);
        load_s      = row_ready_s && (!valid_r || o_ready);
        accept_s    = valid_r && o_ready;
        last_row_s  = (count_r == LAST_ROW);
    end

    // One-deep output register; reload in the accept cycle keeps 1 row/clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            data_r  <= head_s;
        end else if (accept_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Row-in-tile counter and the pulse following a tile's last accepted row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= {CW{1'b0}};
            tile_done_r <= 1'b0;
        end else begin
            tile_done_r <= accept_s && last_row_s;
            if (accept_s) begin
                count_r <= last_row_s ? {CW{1'b0}} : (count_r + CNT_ONE);
            end
        end
    end

    // Sticky drop indicator: the array has no backpressure, so a write to a full lane is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (|(i_valid & full));
        end
    end

    assign o_valid   = valid_r;
    assign o_data    = data_r;
    assign o_last    = valid_r && last_row_s;
    assign tile_done = tile_done_r;
    assign overflow  = overflow_r;

endmodule
